// File: rtl/ram_stream_reader.sv
// Streams a contiguous run of RAM words onto a valid/ready port through a 2-entry credit-managed buffer.
// Optional: define RAM_STREAM_READER_WRAP_EN to let a run wrap from DEPTH-1 back to address 0.
module ram_stream_reader #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   localparam logic [ADDR_WIDTH+1:0] DEPTH_X   = (ADDR_WIDTH+2)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] TOP_ADDR  = ADDR_WIDTH'(DEPTH - 1);

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   cur_addr_reg, ram_addr_reg, addr_next;
   logic [ADDR_WIDTH:0]     remaining_reg;
   logic                    inflight_reg, inflight_last_reg;
   logic                    done_reg, err_reg;
   logic [DATA_WIDTH-1:0]   data_mem [2];
   logic                    last_mem [2];
   logic                    wr_ptr_reg, rd_ptr_reg;
   logic [1:0]              count_reg;
   logic                    pop, issue, launch, reject, finish, credit_ok, out_of_range;
   logic [ADDR_WIDTH+1:0]   base_x, length_x, end_x;

   assign base_x   = {2'b00, base_addr};
   assign length_x = {1'b0, length};
   assign end_x    = base_x + length_x;

`ifdef RAM_STREAM_READER_WRAP_EN
   assign out_of_range = (base_x >= DEPTH_X) || (length_x > DEPTH_X);
   assign addr_next    = (cur_addr_reg == TOP_ADDR) ? '0 : cur_addr_reg + 1'b1;
`else
   assign out_of_range = (base_x >= DEPTH_X) || (end_x > DEPTH_X);
   assign addr_next    = cur_addr_reg + 1'b1;
`endif

   assign out_valid = (count_reg != 2'd0);
   assign out_data  = data_mem[rd_ptr_reg];
   assign out_last  = out_valid && last_mem[rd_ptr_reg];
   assign pop       = out_valid && out_ready;
   assign busy      = (state_reg != IDLE);
   assign done      = done_reg;
   assign err       = err_reg;
   assign ram_we    = 1'b0;

   // Buffered words plus the one in flight may never exceed the two buffer slots.
   assign credit_ok = ({1'b0, count_reg} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop});

   assign ram_addr  = issue ? cur_addr_reg : ram_addr_reg;

   always_comb begin
      state_next = state_reg;
      issue      = 1'b0;
      launch     = 1'b0;
      reject     = 1'b0;
      finish     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (out_of_range) begin
                  reject = 1'b1;
               end else begin
                  launch     = 1'b1;
                  state_next = (length == '0) ? DRAIN : READ;
               end
            end
         end
         READ: begin
            issue = credit_ok;
            if (issue && remaining_reg == (ADDR_WIDTH+1)'(1)) state_next = DRAIN;
         end
         DRAIN: begin
            // The empty/idle term only fires for zero-length commands; otherwise the last pop ends it.
            if ((pop && out_last) || (count_reg == 2'd0 && !inflight_reg)) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg         <= IDLE;
         cur_addr_reg      <= '0;
         ram_addr_reg      <= '0;
         remaining_reg     <= '0;
         inflight_reg      <= 1'b0;
         inflight_last_reg <= 1'b0;
         done_reg          <= 1'b0;
         err_reg           <= 1'b0;
      end else begin
         state_reg         <= state_next;
         ram_addr_reg      <= ram_addr;
         inflight_reg      <= issue;
         inflight_last_reg <= issue && (remaining_reg == (ADDR_WIDTH+1)'(1));
         done_reg          <= finish;
         err_reg           <= reject;
         if (launch) begin
            cur_addr_reg  <= base_addr;
            remaining_reg <= length;
         end else if (issue) begin
            cur_addr_reg  <= addr_next;
            remaining_reg <= remaining_reg - 1'b1;
         end
      end
   end

   // RAM data for last cycle's issue lands here; simultaneous write and pop keep the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_mem[0] <= '0;
         data_mem[1] <= '0;
         last_mem[0] <= 1'b0;
         last_mem[1] <= 1'b0;
         wr_ptr_reg  <= 1'b0;
         rd_ptr_reg  <= 1'b0;
         count_reg   <= 2'd0;
      end else begin
         if (inflight_reg) begin
            data_mem[wr_ptr_reg] <= ram_rdata;
            last_mem[wr_ptr_reg] <= inflight_last_reg;
            wr_ptr_reg           <= ~wr_ptr_reg;
         end
         if (pop) rd_ptr_reg <= ~rd_ptr_reg;
         case ({inflight_reg, pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Sequential read-out engine placed directly downstream of the single-port `ram` block. On a `start` command it reads a contiguous run of words (`base_addr` .. `base_addr+length-1`) from the RAM. It hides the RAM's one-cycle registered read latency and presents the words in order on a valid/ready stream toward the alignment datapath. A 2-entry output buffer with credit-based issue sustains one word per cycle and tolerates arbitrary backpressure.

## Interface
Parameters:
- `ADDR_WIDTH`, default 12: RAM address width; must match the attached `ram`.
- `DATA_WIDTH`, default 32: RAM word width.
- `DEPTH`, default 64: number of valid RAM words; addresses 0..DEPTH-1.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `start`, in, 1: command strobe; sampled only in IDLE.
- `base_addr`, in, ADDR_WIDTH: first word address; captured with `start`.
- `length`, in, ADDR_WIDTH+1: word count, 0..DEPTH; captured with `start`.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse when a command completes.
- `err`, out, 1: one-cycle pulse when a command is rejected.
- `ram_addr`, out, ADDR_WIDTH: drives `ram.addr`.
- `ram_we`, out, 1: drives `ram.we`; constant 0.
- `ram_rdata`, in, DATA_WIDTH: from `ram.data_out`.
- `out_data`, out, DATA_WIDTH: stream data.
- `out_valid`, out, 1: stream valid.
- `out_ready`, in, 1: stream ready from the consumer.
- `out_last`, out, 1: marks the final word of a command; qualified by `out_valid`.

## Operation
- States:
  - IDLE: waits for a command.
  - READ: issues RAM reads.
  - DRAIN: all reads issued; waits for the buffer to empty.
- Transitions from IDLE when `start`=1:
  - `length`=0: go to DRAIN. No reads are issued.
  - Out-of-range command (see Configuration): pulse `err` next cycle and stay in IDLE.
  - Otherwise: go to READ. Capture the address and a remaining count equal to `length`.
- Issue rule in READ:
  - `pop` = `out_valid && out_ready`.
  - A read is issued in a cycle only if `fifo_count + inflight - pop < 2`.
  - Issuing drives `ram_addr` to the current address, then increments the address and decrements the remaining count.
- After the last issue, go to DRAIN.
- DRAIN to IDLE: when the buffer is empty, no read is in flight and the final word has been popped. `done` pulses in the cycle after that pop. For `length`=0, `done` pulses in the cycle after entering DRAIN.
- Capture: data for a read issued in cycle t appears on `ram_rdata` in cycle t+1 and is written into the FIFO at the end of cycle t+1.
- The FIFO never overflows; the credit rule guarantees `fifo_count + inflight` ≤ 2.
- `out_data`/`out_valid`/`out_last` come from the FIFO head.
- Once `out_valid` is asserted, it, `out_data` and `out_last` stay stable until the word is popped.
- `start` is ignored while `busy`.
- When not issuing, `ram_addr` holds its last value. The resulting spurious RAM reads are discarded.
- Address arithmetic is modulo 2^ADDR_WIDTH internally. The range check uses ADDR_WIDTH+2-bit sums.

## Timing
- Values after reset: `busy`, `done`, `err`, `out_valid`, `out_last` = 0; `ram_addr` = 0; `out_data` = 0. FIFO is empty, state is IDLE.
- Cycle 0: `start` high and accepted.
- Cycle 1: first issue, with `ram_addr` = base.
- Cycle 2: `ram_rdata` = mem[base].
- Cycle 3: `out_valid`=1 with that word.
- Start-to-first-valid latency is 3 cycles.
- With `out_ready` held high the stream runs at one word per cycle. An N-word command gives `out_valid` in cycles 3..N+2 and `done` in cycle N+3.
- `out_ready` low freezes the output. At most 2 words (buffered plus in flight) arrive after the stall begins; issue resumes in the cycle the stall ends.
- A new `start` is accepted at the earliest in the cycle `done` is high.
- `rst` asserted at any time, including mid-command, immediately flushes the FIFO and in-flight state, returns to IDLE and forces all outputs to their reset values. No `done` or `err` is generated.

## Configuration
- Macro: `RAM_STREAM_READER_WRAP_EN`.
- Defined:
  - The address wraps to 0 after DEPTH-1, so a run may cross the top of memory.
  - Only `length` > DEPTH or `base_addr` ≥ DEPTH raises `err`.
- Undefined:
  - Any command with `base_addr + length > DEPTH` raises `err`, also `base_addr` ≥ DEPTH.
  - No reads are issued for a rejected command.

## Test plan
- mem[i]=0x100+i, start base=4, length=8, `out_ready`=1 → words 0x104..0x10B on cycles 3..10; `out_last` only on 0x10B; `done` in cycle 11.
- Same command with `out_ready` toggled randomly → identical ordered sequence with no drops or duplicates; `out_data` stable while stalled; `ram_we` always 0.
- length=0 → `done` 2 cycles after start; `out_valid` never asserted.
- base=60, length=8, DEPTH=64:
  - Without macro: `err` pulse, no `out_valid`.
  - With macro: words mem[60..63], mem[0..3].
- `rst` pulsed at cycle 5 of a 16-word command → all outputs 0 immediately; a following start base=0, length=2 returns mem[0], mem[1] correctly.
- `start` pulsed again while `busy` → ignored; only one `done`, original word count.
